// File: rtl/alu_retire_stage.sv
// Execute-to-writeback stage behind the SPARCv8 integer ALU: retires one result per
// instruction, owns the architectural ICC/Y registers and turns ALU faults into precise traps.
module alu_retire_stage #(
  parameter logic [7:0] TT_DIV_ZERO = 8'h2A,
  parameter logic [7:0] TT_TAG_OVF  = 8'h0A,
  parameter logic [3:0] ICC_RESET   = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_pc,
  input  logic [31:0] alu_rd,
  input  logic [3:0]  alu_icc,
  input  logic [31:0] alu_y,
  input  logic        alu_div_zero,
  input  logic        alu_tag_ovf,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        rf_gnt,
  output logic [3:0]  icc_cur,
  output logic [31:0] y_cur,
  output logic        trap_req,
  output logic [7:0]  trap_tt,
  output logic [31:0] trap_pc,
  input  logic        trap_ack,
  input  logic        et,
  output logic        error_mode
);

  // The op3 groups 0x1x and 0x20..0x24 all set the condition codes.
  function automatic logic is_cc_writer(input logic [5:0] op);
    logic r;
    r = 1'b0;
    if (op[5:4] == 2'b01) begin
      r = 1'b1;
    end else if ((op[5:3] == 3'b100) && (op[2:0] <= 3'd4)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic is_y_writer(input logic [5:0] op);
    logic r;
    case (op)
      6'h0A, 6'h0B, 6'h1A, 6'h1B, 6'h24: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  logic        v_r;
  logic [5:0]  opcode_r;
  logic [4:0]  rd_r;
  logic [31:0] data_r;
  logic [3:0]  icc_in_r;
  logic [31:0] y_in_r;
  logic [7:0]  tt_r;
  logic        trap_r;
  logic [31:0] pc_r;
  logic [3:0]  icc_r;
  logic [31:0] y_r;
  logic        err_r;

  logic        rf_we_s;
  logic        retire_s;
  logic        trap_req_s;
  logic        trap_take_s;
  logic        in_ready_s;
  logic        accept_s;
  logic [3:0]  icc_cur_s;
  logic [31:0] y_cur_s;

  // Handshake, retire and forwarding decode; everything derives from stage registers and rf_gnt.
  always_comb begin
    rf_we_s     = v_r && !trap_r && (rd_r != 5'd0);
    retire_s    = v_r && !trap_r && (!rf_we_s || rf_gnt);
    trap_req_s  = v_r && trap_r;
    trap_take_s = trap_req_s && trap_ack;
    in_ready_s  = !err_r && (!v_r || retire_s);
    accept_s    = in_valid && in_ready_s;
    if (retire_s && is_cc_writer(opcode_r)) begin
      icc_cur_s = icc_in_r;
    end else begin
      icc_cur_s = icc_r;
    end
    if (retire_s && is_y_writer(opcode_r)) begin
      y_cur_s = y_in_r;
    end else begin
      y_cur_s = y_r;
    end
  end

  assign in_ready   = in_ready_s;
  assign rf_we      = rf_we_s;
  assign rf_waddr   = rd_r;
  assign rf_wdata   = data_r;
  assign icc_cur    = icc_cur_s;
  assign y_cur      = y_cur_s;
  assign trap_req   = trap_req_s;
  assign trap_tt    = trap_req_s ? tt_r : 8'h00;
  assign trap_pc    = trap_req_s ? pc_r : 32'h0000_0000;
  assign error_mode = err_r;

  // Single-entry stage: capture on accept, drop on retire or taken trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r      <= 1'b0;
      opcode_r <= 6'd0;
      rd_r     <= 5'd0;
      data_r   <= 32'd0;
      icc_in_r <= 4'd0;
      y_in_r   <= 32'd0;
      tt_r     <= 8'd0;
      trap_r   <= 1'b0;
      pc_r     <= 32'd0;
    end else if (accept_s) begin
      v_r      <= 1'b1;
      opcode_r <= in_opcode;
      rd_r     <= in_rd_addr;
      data_r   <= alu_rd;
      icc_in_r <= alu_icc;
      y_in_r   <= alu_y;
      trap_r   <= alu_div_zero || alu_tag_ovf;
      pc_r     <= in_pc;
      if (alu_div_zero) begin
        tt_r <= TT_DIV_ZERO;
      end else if (alu_tag_ovf) begin
        tt_r <= TT_TAG_OVF;
      end else begin
        tt_r <= 8'd0;
      end
    end else if (retire_s || trap_take_s) begin
      v_r <= 1'b0;
    end else begin
      v_r <= v_r;
    end
  end

  // Architectural ICC/Y commit on retire; error mode latches when a trap is taken with ET clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icc_r <= ICC_RESET;
      y_r   <= 32'd0;
      err_r <= 1'b0;
    end else begin
      if (retire_s && is_cc_writer(opcode_r)) begin
        icc_r <= icc_in_r;
      end
      if (retire_s && is_y_writer(opcode_r)) begin
        y_r <= y_in_r;
      end
      if (trap_take_s && !et) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_retire_stage.sv
// Self-checking bench for alu_retire_stage: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_alu_retire_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_pc, alu_rd, alu_y;
  logic [3:0]  alu_icc;
  logic        alu_div_zero, alu_tag_ovf;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_gnt;
  logic [3:0]  icc_cur;
  logic [31:0] y_cur;
  logic        trap_req;
  logic [7:0]  trap_tt;
  logic [31:0] trap_pc;
  logic        trap_ack, et, error_mode;

  int n_chk = 0;
  int n_err = 0;

  alu_retire_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd_addr(in_rd_addr), .in_pc(in_pc),
    .alu_rd(alu_rd), .alu_icc(alu_icc), .alu_y(alu_y),
    .alu_div_zero(alu_div_zero), .alu_tag_ovf(alu_tag_ovf),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_gnt(rf_gnt),
    .icc_cur(icc_cur), .y_cur(y_cur),
    .trap_req(trap_req), .trap_tt(trap_tt), .trap_pc(trap_pc),
    .trap_ack(trap_ack), .et(et), .error_mode(error_mode)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one pending instruction plus architectural state.
  logic        m_v;
  logic [5:0]  m_op;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_y_in, m_pc, m_y;
  logic [3:0]  m_icc_in, m_icc;
  logic [7:0]  m_tt;
  logic        m_trap, m_err;

  task automatic model_reset();
    m_v = 1'b0; m_icc = 4'h0; m_y = 32'h0; m_err = 1'b0;
  endtask

  function automatic logic sets_cc(input logic [5:0] op);
    return op inside {[6'h10:6'h24]};
  endfunction

  function automatic logic sets_y(input logic [5:0] op);
    return op inside {6'h0A, 6'h0B, 6'h1A, 6'h1B, 6'h24};
  endfunction

  always @(negedge rst_n) model_reset();

  // Compare process: checks every output each cycle, then advances the model to the next edge.
  initial begin
    logic e_we, e_ret, e_rdy, e_trap;
    logic [3:0]  e_icc;
    logic [31:0] e_y;
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        model_reset();
      end else begin
        e_we   = m_v && !m_trap && (m_rd != 5'd0);
        e_ret  = m_v && !m_trap && ((m_rd == 5'd0) || rf_gnt);
        e_trap = m_v && m_trap;
        e_rdy  = !m_err && (!m_v || e_ret);
        e_icc  = (e_ret && sets_cc(m_op)) ? m_icc_in : m_icc;
        e_y    = (e_ret && sets_y(m_op)) ? m_y_in : m_y;
        chk("m_in_ready", in_ready, e_rdy);
        chk("m_rf_we", rf_we, e_we);
        if (e_we) begin
          chk("m_rf_waddr", rf_waddr, m_rd);
          chk("m_rf_wdata", rf_wdata, m_data);
        end
        chk("m_icc_cur", icc_cur, e_icc);
        chk("m_y_cur", y_cur, e_y);
        chk("m_trap_req", trap_req, e_trap);
        if (e_trap) begin
          chk("m_trap_tt", trap_tt, m_tt);
          chk("m_trap_pc", trap_pc, m_pc);
        end
        chk("m_error_mode", error_mode, m_err);
        if (e_ret) begin
          m_icc = e_icc;
          m_y   = e_y;
          m_v   = 1'b0;
        end
        if (e_trap && trap_ack) begin
          m_v = 1'b0;
          if (!et) m_err = 1'b1;
        end
        if (in_valid && e_rdy) begin
          m_v = 1'b1; m_op = in_opcode; m_rd = in_rd_addr; m_data = alu_rd;
          m_icc_in = alu_icc; m_y_in = alu_y; m_pc = in_pc;
          m_trap = alu_div_zero || alu_tag_ovf;
          m_tt = alu_div_zero ? 8'h2A : (alu_tag_ovf ? 8'h0A : 8'h00);
        end
      end
    end
  end

  task automatic idle();
    in_valid = 1'b0; alu_div_zero = 1'b0; alu_tag_ovf = 1'b0;
    trap_ack = 1'b0; rf_gnt = 1'b1; et = 1'b1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] data,
                       input logic [3:0] icc, input logic [31:0] y, input logic dz,
                       input logic to, input logic [31:0] pc);
    in_valid = 1'b1; in_opcode = op; in_rd_addr = rd; alu_rd = data; alu_icc = icc;
    alu_y = y; alu_div_zero = dz; alu_tag_ovf = to; in_pc = pc;
  endtask

  initial begin
    idle();
    issue(6'h00, 5'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_icc_cur", icc_cur, 4'h0);
    chk("rst_y_cur", y_cur, 32'h0);
    chk("rst_trap_req", trap_req, 1'b0);
    chk("rst_error_mode", error_mode, 1'b0);

    // ADDcc to r5, immediate grant
    @(negedge clk); idle(); issue(6'h10, 5'd5, 32'h0, 4'b0100, 32'h0, 1'b0, 1'b0, 32'h100);
    @(negedge clk); idle(); #3;
    chk("addcc_we", rf_we, 1'b1);
    chk("addcc_waddr", rf_waddr, 5'd5);
    chk("addcc_wdata", rf_wdata, 32'h0);
    chk("addcc_icc_fwd", icc_cur, 4'b0100);

    // UMUL to r3 stalled three cycles on the register-file port
    @(negedge clk); idle(); issue(6'h0A, 5'd3, 32'hDEAD, 4'b1111, 32'h1, 1'b0, 1'b0, 32'h104); #3;
    chk("icc_reg_after_addcc", icc_cur, 4'b0100);
    repeat (3) begin
      @(negedge clk); idle(); rf_gnt = 1'b0; #3;
      chk("umul_stall_we", rf_we, 1'b1);
      chk("umul_stall_ready", in_ready, 1'b0);
      chk("umul_stall_y", y_cur, 32'h0);
    end
    @(negedge clk); idle(); #3;
    chk("umul_gnt_ready", in_ready, 1'b1);
    chk("umul_y_fwd", y_cur, 32'h1);
    @(negedge clk); idle(); #3;
    chk("umul_y_reg", y_cur, 32'h1);
    chk("umul_icc_unchanged", icc_cur, 4'b0100);

    // SUBcc to %g0, then ADDXcc back-to-back in its retire cycle
    @(negedge clk); idle(); issue(6'h14, 5'd0, 32'h123, 4'b1010, 32'h0, 1'b0, 1'b0, 32'h108);
    @(negedge clk); idle(); issue(6'h18, 5'd7, 32'h77, 4'b0011, 32'h0, 1'b0, 1'b0, 32'h10C); #3;
    chk("g0_no_we", rf_we, 1'b0);
    chk("g0_ready", in_ready, 1'b1);
    chk("g0_icc_fwd", icc_cur, 4'b1010);
    @(negedge clk); idle(); #3;
    chk("addx_we", rf_we, 1'b1);
    chk("addx_waddr", rf_waddr, 5'd7);
    chk("addx_wdata", rf_wdata, 32'h77);
    chk("addx_icc_fwd", icc_cur, 4'b0011);

    // UDIVcc divide by zero traps, no architectural update
    @(negedge clk); idle(); issue(6'h1E, 5'd9, 32'h5, 4'b1111, 32'h99, 1'b1, 1'b0, 32'h4000_1000); #3;
    chk("icc_reg_after_addx", icc_cur, 4'b0011);
    repeat (2) begin
      @(negedge clk); idle(); #3;
      chk("dz_trap_req", trap_req, 1'b1);
      chk("dz_trap_tt", trap_tt, 8'h2A);
      chk("dz_trap_pc", trap_pc, 32'h4000_1000);
      chk("dz_rf_we", rf_we, 1'b0);
      chk("dz_ready", in_ready, 1'b0);
    end
    @(negedge clk); idle(); trap_ack = 1'b1; #3;
    chk("dz_req_at_ack", trap_req, 1'b1);
    @(negedge clk); idle(); #3;
    chk("dz_req_dropped", trap_req, 1'b0);
    chk("dz_icc_kept", icc_cur, 4'b0011);
    chk("dz_y_kept", y_cur, 32'h1);

    // TADDccTV tag overflow taken with ET=0 enters sticky error mode
    @(negedge clk); idle(); issue(6'h22, 5'd2, 32'h8, 4'b0010, 32'h0, 1'b0, 1'b1, 32'h4000_2000);
    @(negedge clk); idle(); et = 1'b0; trap_ack = 1'b1; #3;
    chk("tov_trap_tt", trap_tt, 8'h0A);
    repeat (2) begin
      @(negedge clk); idle(); issue(6'h00, 5'd1, 32'h1, 4'h0, 32'h0, 1'b0, 1'b0, 32'h200); #3;
      chk("err_mode_set", error_mode, 1'b1);
      chk("err_ready", in_ready, 1'b0);
    end
    @(negedge clk); idle(); rst_n = 1'b0; #3;
    chk("err_rst_mode", error_mode, 1'b0);
    chk("err_rst_ready", in_ready, 1'b1);
    chk("err_rst_icc", icc_cur, 4'h0);
    @(negedge clk); rst_n = 1'b1;

    // Reset while UMULcc is stalled: write request drops asynchronously
    @(negedge clk); idle(); issue(6'h1A, 5'd4, 32'hAB, 4'b0110, 32'h55, 1'b0, 1'b0, 32'h300);
    @(negedge clk); idle(); rf_gnt = 1'b0; #3;
    chk("stall_we", rf_we, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("async_we_drop", rf_we, 1'b0);
    @(negedge clk); rst_n = 1'b1; #3;
    chk("post_rst_icc", icc_cur, 4'h0);
    chk("post_rst_y", y_cur, 32'h0);
    chk("post_rst_we", rf_we, 1'b0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 800; i++) begin
      logic [5:0] op;
      @(negedge clk);
      idle();
      case ($urandom_range(0, 5))
        0: op = 6'h10;
        1: op = 6'h0A;
        2: op = 6'h24;
        3: op = 6'h1B;
        default: op = 6'($urandom_range(0, 63));
      endcase
      issue(op, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
            4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0, $urandom);
      in_valid = $urandom_range(0, 9) < 7;
      rf_gnt   = $urandom_range(0, 9) < 7;
      trap_ack = $urandom_range(0, 9) < 4;
    end

    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_retire_stage.md
Name: alu_retire_stage

Overview:
- Registered execute-to-writeback stage placed directly downstream of the SPARCv8 integer ALU.
- Captures one ALU result per accepted instruction and writes rd to the register file.
- Owns the architectural ICC and Y registers and feeds their current values back to the ALU icc_in/Y_in inputs.
- Converts the ALU division_by_zero and tag_overflow flags into precise trap requests.

Parameters:
- TT_DIV_ZERO, 8'h2A, trap type reported for division by zero.
- TT_TAG_OVF, 8'h0A, trap type reported for tag overflow.
- ICC_RESET, 4'h0, reset value of the ICC register (NZVC).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  issue presents an executed instruction this cycle.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready.
- in_opcode  in  6  ALU opcode (op3) of the instruction.
- in_rd_addr  in  5  destination register.
- in_pc  in  32  PC of the instruction.
- alu_rd  in  32  ALU result.
- alu_icc  in  4  ALU NZVC output.
- alu_y  in  32  ALU Y output.
- alu_div_zero  in  1  ALU division_by_zero flag.
- alu_tag_ovf  in  1  ALU tag_overflow flag.
- rf_we  out  1  register-file write request.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- rf_gnt  in  1  register-file port granted this cycle (shared with the load unit).
- icc_cur  out  4  forwarded ICC value, drives ALU icc_in.
- y_cur  out  32  forwarded Y value, drives ALU Y_in.
- trap_req  out  1  trap pending.
- trap_tt  out  8  trap type.
- trap_pc  out  32  PC of the trapping instruction.
- trap_ack  in  1  trap unit has taken the trap.
- et  in  1  PSR.ET (enable traps).
- error_mode  out  1  sticky error-mode flag.

Behaviour:
- **Stage state:** one entry: v_q, opcode_q, rd_q, data_q, icc_q_in, y_q_in, tt_q, trap_q, pc_q.
- **Accept:** on in_valid && in_ready, all inputs are captured and v_q is set. Trap priority on capture: alu_div_zero → TT_DIV_ZERO, else alu_tag_ovf → TT_TAG_OVF; trap_q = either flag set.
- **Opcode classes:**
  - cc-writer when opcode[5:4]==2'b01, or opcode is one of 0x20–0x24.
  - Y-writer when opcode is one of 0x0A, 0x0B, 0x1A, 0x1B, 0x24.
  - Every other opcode writes neither ICC nor Y.
- **Register-file write:** rf_we = v_q && !trap_q && rd_q!=0. rf_waddr = rd_q, rf_wdata = data_q. All three are driven from registers only (no in_* combinational path).
- **Retire:** retire = v_q && !trap_q && (!rf_we || rf_gnt). rd_q==0 (%g0) retires without a write request.
- **On retire edge:**
  - ICC register ← icc_q_in if the entry is a cc-writer.
  - Y register ← y_q_in if the entry is a Y-writer.
  - v_q is cleared unless a new entry is accepted in the same cycle.
- **Ready:** in_ready = !v_q || retire. Accept and retire in the same cycle is legal, giving back-to-back throughput of 1/cycle. Latency is 1 cycle from accept to rf_we.
- **Forwarding:**
  - icc_cur = (retire && cc-writer) ? icc_q_in : ICC register.
  - y_cur = (retire && Y-writer) ? y_q_in : Y register.
  - The instruction issuing in the retire cycle therefore sees the retiring flags.
- **Trap handling:**
  - When v_q && trap_q: trap_req=1, trap_tt=tt_q, trap_pc=pc_q, rf_we=0, in_ready=0. ICC and Y are not updated.
  - On trap_ack the entry is discarded (v_q←0); trap_req drops the next cycle.
  - trap_ack without trap_req is ignored.
- **Trap with traps disabled:** if the trap is taken while et==0, error_mode sets on the trap_ack edge and stays set until reset. While error_mode=1, in_ready=0.
- **Reset (async, asserted):** v_q=0, rf_we=0, rf_waddr=0, rf_wdata=0, ICC register=ICC_RESET, Y register=0, trap_req=0, trap_tt=0, trap_pc=0, error_mode=0. Therefore icc_cur=ICC_RESET, y_cur=0, in_ready=1 after release. Reset mid-stall or mid-trap discards the entry with no register-file, ICC or Y update.

Test Plan:
- ADDcc (0x10), rd=5, alu_rd=0x00000000, alu_icc=4'b0100, rf_gnt=1 → rf_we next cycle with waddr=5, wdata=0; icc_cur=4'b0100 in that cycle; ICC register=4'b0100 after.
- UMUL (0x0A), rd=3, alu_y=0x00000001, rf_gnt held 0 for 3 cycles → rf_we held with in_ready=0 for 3 cycles; on grant the Y register=1; ICC unchanged.
- SUBcc to rd=0 followed back-to-back by ADDXcc → no rf_we for the first; the second is accepted in the retire cycle and sees icc_cur equal to the first instruction's alu_icc.
- UDIV with alu_div_zero=1, pc=0x40001000 → trap_req=1, trap_tt=0x2A, trap_pc=0x40001000, rf_we=0, in_ready=0 until trap_ack; ICC and Y unchanged.
- TADDccTV with alu_tag_ovf=1, et=0, then trap_ack → error_mode=1 sticky and in_ready=0; assert rst_n=0 → error_mode=0, in_ready=1, icc_cur=0.
- rst_n asserted while an entry is stalled on rf_gnt=0 → rf_we falls immediately (async); no Y or ICC change after release.
